// File: rtl/mc8051_mc_sequencer_pkg.sv
// Shared constants and phase type for the 8051 microcode sequencer.
// Phases S1..S6 make up one machine cycle; S0 exists only right after reset.
package mc8051_mc_sequencer_pkg;

  localparam int MCODE_WIDTH = 64;
  localparam int ROM_AW      = 10;
  localparam int MAX_MCYC    = 4;

  localparam logic [7:0] IRQ_OPCODE = 8'hA5;
  localparam logic [7:0] NOP_OPCODE = 8'h00;

  typedef enum logic [3:0] {
    S0 = 4'd0,
    S1 = 4'd1,
    S2 = 4'd2,
    S3 = 4'd3,
    S4 = 4'd4,
    S5 = 4'd5,
    S6 = 4'd6
  } phase_e;

  // Unused encodings fall back to S1 so a corrupted phase recovers in one clock.
  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      S0:      n = S1;
      S1:      n = S2;
      S2:      n = S3;
      S3:      n = S4;
      S4:      n = S5;
      S5:      n = S6;
      S6:      n = S1;
      default: n = S1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mc8051_phase_gen.sv
// Machine-cycle phase generator: S0 after reset, then S1..S6 repeating.
// A stall holds the current phase, so the next phase equals the current one.
module mc8051_phase_gen
  import mc8051_mc_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  output logic [3:0] t_p_d,
  output logic [3:0] t_p_q
);

  phase_e state;
  phase_e state_nxt;

  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!stall) state_nxt = next_phase(state);
  end

  assign t_p_d = state_nxt;
  assign t_p_q = state;

endmodule

// File: rtl/mc8051_mc_sequencer.sv
// Microcode sequencer: forms the ROM address from {cycle index, opcode}, registers
// the ROM word, and handles multi-cycle instructions, stalls and interrupt injection.
module mc8051_mc_sequencer
  import mc8051_mc_sequencer_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_opcode,
  input  logic                   i_opcode_vld,
  input  logic                   i_stall,
  input  logic                   i_irq_req,
  input  logic                   i_irq_block,
  output logic [ROM_AW-1:0]      o_rom_addr,
  input  logic [MCODE_WIDTH-1:0] i_rom_data,
  output logic [MCODE_WIDTH-1:0] o_mc_b,
  output logic [3:0]             o_t_p_d,
  output logic [3:0]             o_t_p_q,
  output logic [1:0]             o_mcyc_idx,
  output logic                   o_opcode_ack,
  output logic                   o_irq_ack,
  output logic                   o_inst_done,
  output logic                   o_mc_err
);

  logic [7:0] op_latch;
  logic [7:0] sel_op;
  logic [1:0] idx_inc;
  logic       at_s0;
  logic       at_s1;
  logic       boundary;
  logic       more;
  logic       at_max;
  logic       cont;
  logic       last;
  logic       irq_take;
  logic       op_take;
  logic       forced;

  mc8051_phase_gen u_phase_gen (
    .clk   (clk),
    .reset (reset),
    .stall (i_stall),
    .t_p_d (o_t_p_d),
    .t_p_q (o_t_p_q)
  );

  assign at_s0    = (o_t_p_q == S0);
  assign at_s1    = (o_t_p_q == S1);
  assign boundary = ~i_stall & ((o_t_p_q == S6) | at_s0);
  assign more     = o_mc_b[MCODE_WIDTH-1];
  assign at_max   = (o_mcyc_idx == 2'(MAX_MCYC - 1));
  assign idx_inc  = o_mcyc_idx + 2'd1;

  // The S0 boundary always starts a fresh instruction and never counts as a finish.
  assign cont     = boundary & ~at_s0 & more & ~at_max;
  assign last     = boundary & ~cont;
  assign irq_take = last & ~at_s0 & i_irq_req & ~i_irq_block;
  assign op_take  = last & ~irq_take & i_opcode_vld;
  assign forced   = last & ~at_s0 & more & at_max;

  always_comb begin
    sel_op = NOP_OPCODE;
    if (irq_take)     sel_op = IRQ_OPCODE;
    else if (op_take) sel_op = i_opcode;
  end

  assign o_inst_done  = ~reset & last & ~at_s0;
  assign o_irq_ack    = ~reset & irq_take;
  assign o_opcode_ack = ~reset & op_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      o_rom_addr <= '0;
      o_mc_b     <= '0;
      o_mcyc_idx <= 2'd0;
      op_latch   <= NOP_OPCODE;
      o_mc_err   <= 1'b0;
    end else begin
      if (cont) begin
        o_mcyc_idx <= idx_inc;
        o_rom_addr <= {idx_inc, op_latch};
      end else if (last) begin
        o_mcyc_idx <= 2'd0;
        op_latch   <= sel_op;
        o_rom_addr <= {2'b00, sel_op};
      end
      if (forced) o_mc_err <= 1'b1;
      // ROM address settles during S1, so the word is captured on the S1 exit edge.
      if (~i_stall & at_s1) o_mc_b <= i_rom_data;
    end
  end

endmodule
